// File: rtl/c4_sequencer.sv
// ---------------------------------------------------------------------------
// c4_sequencer
//
// Stimulus sequencer for the c4 lab state machine. Commands {a, c, repeat}
// are queued in a small FIFO. On start the sequencer pulses a synchronous
// clear into c4, then plays the queued commands onto c4's a/c inputs back to
// back, holding each one for repeat+1 cycles. While playing, it counts the
// cycles in which c4's n output is high.
//
// Parameters:
//   DEPTH  command FIFO entries (power of two, >= 2)
//   CNT_W  width of the repeat field and of the hit counter
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  command present on cmd_a/cmd_c/cmd_rep
//   cmd_a      value for c4 input a
//   cmd_c      value for c4 input c
//   cmd_rep    extra hold cycles (command applied cmd_rep+1 cycles)
//   cmd_ready  FIFO can accept a command (not full)
//   start      begin a run (only honoured in IDLE)
//   abort      cancel the run and flush the FIFO
//   n_in       n output of c4
//   a_out      drives c4 a
//   c_out      drives c4 c
//   fsm_rst    one-cycle synchronous clear pulse to c4
//   busy       run in progress (CLEAR and RUN)
//   done       one-cycle run-complete pulse
//   hits       number of RUN cycles with n_in=1 (saturating)
//   first_hit  (C4_SEQ_FIRST_HIT_EN only) RUN cycle index of the first hit,
//              all-ones when no hit has been seen since the last clear
//
// Optional feature macro: C4_SEQ_FIRST_HIT_EN
// ---------------------------------------------------------------------------
module c4_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic             cmd_a,
  input  logic             cmd_c,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic             cmd_ready,
  input  logic             start,
  input  logic             abort,
  input  logic             n_in,
  output logic             a_out,
  output logic             c_out,
  output logic             fsm_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits
`ifdef C4_SEQ_FIRST_HIT_EN
  ,
  output logic [CNT_W-1:0] first_hit
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_F = PTR_W + 1;
  localparam logic [CNT_F-1:0] FULL_CNT = CNT_F'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_VAL  = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  typedef struct packed {
    logic             a;
    logic             c;
    logic [CNT_W-1:0] rep;
  } cmd_t;

  state_t           state;
  state_t           next_state;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_F-1:0] count;
  logic [CNT_F-1:0] held;

  logic [CNT_W-1:0] rem;
  logic             first;
  logic [CNT_W-1:0] eff_rem;
  cmd_t             head;
  cmd_t             next_head;
  logic             next_head_valid;
  logic             push;
  logic             pop;

  logic             a_next;
  logic             c_next;
  logic             fsm_rst_next;
  logic             busy_next;
  logic             done_next;

  assign cmd_ready = (count != FULL_CNT);

  // FIFO control and look-ahead of the entry that will sit at the head next
  // cycle. a_out/c_out are registered, so they must be loaded with the head
  // as it will be after this cycle's pop/push. When the FIFO drains to empty
  // in the same cycle a new command arrives, that command is forwarded.
  always_comb begin
    head    = mem[rd_ptr];
    eff_rem = first ? head.rep : rem;
    push    = cmd_valid && cmd_ready && !abort;
    pop     = (state == RUN) && (count != '0) && (eff_rem == '0) && !abort;
    held    = count - CNT_F'(pop);
    if (held == '0) begin
      next_head_valid = push;
      next_head       = {cmd_a, cmd_c, cmd_rep};
    end else begin
      next_head_valid = 1'b1;
      next_head       = mem[rd_ptr + PTR_W'(pop)];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_c, cmd_rep};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_F'(push) - CNT_F'(pop);
    end
  end

  // Per-command hold counter. 'first' marks the first cycle of a command, in
  // which the head's repeat value is used directly instead of 'rem'.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      first <= 1'b1;
    end else if (state == CLEAR) begin
      rem   <= '0;
      first <= 1'b1;
    end else if ((state == RUN) && (count != '0) && !abort) begin
      if (pop) begin
        first <= 1'b1;
      end else begin
        first <= 1'b0;
        rem   <= eff_rem - CNT_W'(1);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM: next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = CLEAR;
      CLEAR: next_state = RUN;
      RUN: begin
        if (count == '0) begin
          next_state = DONE;
        end else if (pop && (held == '0) && !push) begin
          next_state = DONE;
        end
      end
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // FSM: output logic, computed from the next state so every output is a flop
  always_comb begin
    a_next       = 1'b0;
    c_next       = 1'b0;
    fsm_rst_next = (next_state == CLEAR);
    busy_next    = (next_state == CLEAR) || (next_state == RUN);
    done_next    = (next_state == DONE);
    if ((next_state == RUN) && next_head_valid) begin
      a_next = next_head.a;
      c_next = next_head.c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out   <= 1'b0;
      c_out   <= 1'b0;
      fsm_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      a_out   <= a_next;
      c_out   <= c_next;
      fsm_rst <= fsm_rst_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Saturating hit counter; frozen by abort so the count survives cancellation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits <= '0;
    end else if (!abort) begin
      if (state == CLEAR) begin
        hits <= '0;
      end else if ((state == RUN) && n_in && (hits != MAX_VAL)) begin
        hits <= hits + CNT_W'(1);
      end
    end
  end

`ifdef C4_SEQ_FIRST_HIT_EN
  logic [CNT_W-1:0] run_idx;
  logic             captured;

  // run_idx is the index of the current RUN cycle; 'captured' keeps a hit
  // that lands on the saturated index distinguishable from "no hit".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_idx   <= '0;
      captured  <= 1'b0;
      first_hit <= MAX_VAL;
    end else if (!abort) begin
      if (state == CLEAR) begin
        run_idx   <= '0;
        captured  <= 1'b0;
        first_hit <= MAX_VAL;
      end else if (state == RUN) begin
        if (run_idx != MAX_VAL) run_idx <= run_idx + CNT_W'(1);
        if (n_in && !captured) begin
          captured  <= 1'b1;
          first_hit <= run_idx;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_c4_sequencer.sv
// ---------------------------------------------------------------------------
// tb_c4_sequencer
//
// Directed testbench for c4_sequencer (DEPTH=4, CNT_W=8). Inputs are driven
// 1 time unit after each rising edge; outputs are checked at the same point,
// so each check sees the state produced by the preceding edge. Build with
// C4_SEQ_FIRST_HIT_EN defined to also exercise first_hit.
// ---------------------------------------------------------------------------
module tb_c4_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_a;
  logic       cmd_c;
  logic [7:0] cmd_rep;
  logic       cmd_ready;
  logic       start;
  logic       abort;
  logic       n_in;
  logic       a_out;
  logic       c_out;
  logic       fsm_rst;
  logic       busy;
  logic       done;
  logic [7:0] hits;
`ifdef C4_SEQ_FIRST_HIT_EN
  logic [7:0] first_hit;
`endif

  int checks   = 0;
  int failures = 0;
  int run_cycles;

  always #5 clk = ~clk;

  c4_sequencer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_a     (cmd_a),
    .cmd_c     (cmd_c),
    .cmd_rep   (cmd_rep),
    .cmd_ready (cmd_ready),
    .start     (start),
    .abort     (abort),
    .n_in      (n_in),
    .a_out     (a_out),
    .c_out     (c_out),
    .fsm_rst   (fsm_rst),
    .busy      (busy),
    .done      (done),
    .hits      (hits)
`ifdef C4_SEQ_FIRST_HIT_EN
    ,
    .first_hit (first_hit)
`endif
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic a, input logic c,
                               input logic [7:0] rep, input logic st,
                               input logic ab, input logic n);
    cmd_valid = v;
    cmd_a     = a;
    cmd_c     = c;
    cmd_rep   = rep;
    start     = st;
    abort     = ab;
    n_in      = n;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Start with an empty FIFO: CLEAR, one RUN cycle with a/c low, then DONE
  task automatic runEmptyStart(input string tag);
    applyStimulus(0, 0, 0, 8'd0, 1, 0, 0);
    tick();
    checkOutput({tag, "_clear_fsm_rst"}, fsm_rst, 1);
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    checkOutput({tag, "_run_a"}, a_out, 0);
    checkOutput({tag, "_run_c"}, c_out, 0);
    checkOutput({tag, "_run_busy"}, busy, 1);
    checkOutput({tag, "_run_done"}, done, 0);
    tick();
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_done_busy"}, busy, 0);
    checkOutput({tag, "_hits"}, hits, 0);
    tick();
    checkOutput({tag, "_done_pulse_end"}, done, 0);
  endtask

  initial begin
    $display("[TB] c4_sequencer directed test");
    rst = 1'b1;
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    #3;
    checkOutput("rst_a_out", a_out, 0);
    checkOutput("rst_c_out", c_out, 0);
    checkOutput("rst_fsm_rst", fsm_rst, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_hits", hits, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
`ifdef C4_SEQ_FIRST_HIT_EN
    checkOutput("rst_first_hit", first_hit, 8'hFF);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Two commands: a=1 for 3 cycles, then c=1 for 1 cycle
    $display("[TB] basic two-command run");
    applyStimulus(1, 1, 0, 8'd2, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 8'd0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 1, 0, 0);
    tick();
    checkOutput("basic_clear_fsm_rst", fsm_rst, 1);
    checkOutput("basic_clear_busy", busy, 1);
    checkOutput("basic_clear_a", a_out, 0);
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("basic_cmd0_a_%0d", i), a_out, 1);
      checkOutput($sformatf("basic_cmd0_c_%0d", i), c_out, 0);
      checkOutput($sformatf("basic_cmd0_busy_%0d", i), busy, 1);
      checkOutput($sformatf("basic_cmd0_fsm_rst_%0d", i), fsm_rst, 0);
    end
    tick();
    checkOutput("basic_cmd1_a", a_out, 0);
    checkOutput("basic_cmd1_c", c_out, 1);
    checkOutput("basic_cmd1_busy", busy, 1);
    checkOutput("basic_cmd1_done", done, 0);
    tick();
    checkOutput("basic_done", done, 1);
    checkOutput("basic_done_busy", busy, 0);
    checkOutput("basic_done_c", c_out, 0);
    checkOutput("basic_hits", hits, 0);
    tick();
    checkOutput("basic_done_pulse_end", done, 0);

    // Fill the FIFO; a fifth command must be refused
    $display("[TB] FIFO full behaviour");
    applyStimulus(1, 1, 0, 8'd0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 8'd0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 1, 8'd0, 0, 0, 0);
    tick();
    checkOutput("full_ready_at3", cmd_ready, 1);
    applyStimulus(1, 0, 0, 8'd0, 0, 0, 0);
    tick();
    checkOutput("full_ready_at4", cmd_ready, 0);
    applyStimulus(1, 1, 1, 8'd0, 0, 0, 0);
    tick();
    checkOutput("full_ready_5th", cmd_ready, 0);
    applyStimulus(0, 0, 0, 8'd0, 1, 0, 0);
    tick();
    checkOutput("full_clear_ready", cmd_ready, 0);
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    checkOutput("full_cmd0_a", a_out, 1);
    checkOutput("full_cmd0_c", c_out, 0);
    checkOutput("full_cmd0_ready", cmd_ready, 0);
    tick();
    checkOutput("full_cmd1_a", a_out, 0);
    checkOutput("full_cmd1_c", c_out, 1);
    checkOutput("full_after_pop_ready", cmd_ready, 1);
    tick();
    checkOutput("full_cmd2_a", a_out, 1);
    checkOutput("full_cmd2_c", c_out, 1);
    tick();
    checkOutput("full_cmd3_a", a_out, 0);
    checkOutput("full_cmd3_c", c_out, 0);
    checkOutput("full_cmd3_busy", busy, 1);
    tick();
    checkOutput("full_done", done, 1);
    checkOutput("full_done_a", a_out, 0);
    tick();

    // One command held 256 cycles with n_in high: hits saturates at 255
    $display("[TB] hit counter saturation");
    applyStimulus(1, 1, 0, 8'd255, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 1);
    tick();
    checkOutput("sat_first_run_a", a_out, 1);
    checkOutput("sat_first_run_hits", hits, 0);
    run_cycles = 0;
    while (!done && run_cycles < 400) begin
      tick();
      run_cycles++;
      if (run_cycles == 10) checkOutput("sat_hits_mid", hits, 10);
    end
    checkOutput("sat_done_seen", done, 1);
    checkOutput("sat_run_length", run_cycles, 256);
    checkOutput("sat_hits", hits, 255);
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    checkOutput("sat_hits_held", hits, 255);

    // Abort in the second RUN cycle with two commands queued
    $display("[TB] abort during run");
    applyStimulus(1, 1, 0, 8'd3, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 8'd0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    checkOutput("abort_run1_a", a_out, 1);
    checkOutput("abort_run1_hits", hits, 0);
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 1);
    tick();
    checkOutput("abort_run2_a", a_out, 1);
    checkOutput("abort_run2_hits", hits, 1);
    applyStimulus(1, 1, 1, 8'd0, 0, 1, 0);
    tick();
    checkOutput("abort_a", a_out, 0);
    checkOutput("abort_c", c_out, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_fsm_rst", fsm_rst, 0);
    checkOutput("abort_hits", hits, 1);
    checkOutput("abort_ready", cmd_ready, 1);
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    checkOutput("abort_no_done", done, 0);
    checkOutput("abort_still_idle", busy, 0);
    runEmptyStart("abort_flush");

    // Asynchronous reset in the middle of a run with three commands queued
    $display("[TB] reset mid-run");
    applyStimulus(1, 1, 1, 8'd5, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 8'd5, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 0, 8'd5, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 1);
    tick();
    tick();
    tick();
    checkOutput("rstmid_pre_a", a_out, 1);
    checkOutput("rstmid_pre_hits", hits, 2);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_a_out", a_out, 0);
    checkOutput("rstmid_c_out", c_out, 0);
    checkOutput("rstmid_fsm_rst", fsm_rst, 0);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_done", done, 0);
    checkOutput("rstmid_hits", hits, 0);
    checkOutput("rstmid_cmd_ready", cmd_ready, 1);
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    runEmptyStart("rstmid_empty");

`ifdef C4_SEQ_FIRST_HIT_EN
    // n_in rises only in RUN cycle 5 of a 10-cycle command
    $display("[TB] first_hit capture");
    applyStimulus(1, 0, 0, 8'd9, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    tick();
    checkOutput("fh_clear_value", first_hit, 8'hFF);
    repeat (5) tick();
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    run_cycles = 0;
    while (!done && run_cycles < 50) begin
      tick();
      run_cycles++;
    end
    checkOutput("fh_done_seen", done, 1);
    checkOutput("fh_first_hit", first_hit, 8'd5);
    checkOutput("fh_hits", hits, 1);
    tick();

    // A run with no hit leaves first_hit at all-ones
    applyStimulus(1, 1, 0, 8'd2, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 8'd0, 0, 0, 0);
    run_cycles = 0;
    while (!done && run_cycles < 50) begin
      tick();
      run_cycles++;
    end
    checkOutput("fh_nohit_done_seen", done, 1);
    checkOutput("fh_nohit_first_hit", first_hit, 8'hFF);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/c4_sequencer.md
Name: c4_sequencer

Overview:
- Stimulus sequencer for the c4 lab state machine.
- Accepts a queue of {a, c, repeat} commands, clears the c4 machine, then drives its a/c inputs one command at a time.
- Counts the cycles in which the c4 n output is high.
- Sits beside c4 in the lab top level: a_out/c_out/fsm_rst feed c4, c4's n feeds n_in.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- CNT_W, 8: width of the repeat field and of the hit counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_a  input  1  value for c4 input a.
- cmd_c  input  1  value for c4 input c.
- cmd_rep  input  CNT_W  extra hold cycles; command is applied for cmd_rep+1 cycles.
- cmd_ready  output  1  FIFO can accept a command.
- start  input  1  begin a run.
- abort  input  1  cancel run, flush FIFO.
- n_in  input  1  n output of c4.
- a_out  output  1  drives c4 a.
- c_out  output  1  drives c4 c.
- fsm_rst  output  1  synchronous clear pulse to c4 rst.
- busy  output  1  run in progress.
- done  output  1  one-cycle run-complete pulse.
- hits  output  CNT_W  number of RUN cycles with n_in=1.

Behaviour:
- Reset: empty FIFO, state IDLE.
  - Outputs on reset: a_out=0, c_out=0, fsm_rst=0, busy=0, done=0, hits=0, cmd_ready=1.
- FIFO:
  - cmd_ready = !full; it depends only on occupancy.
  - Push on cmd_valid & cmd_ready, in any state.
  - When full, a same-cycle pop does not enable a push; cmd_ready stays 0 that cycle.
  - Pointers wrap modulo DEPTH.
  - Count is CLOG2(DEPTH)+1 bits.
- States (registered; all outputs registered):
  - IDLE: a_out=c_out=0, busy=0. start=1 → CLEAR. start is ignored in every other state.
  - CLEAR: fsm_rst=1 for exactly one cycle, busy=1, hits←0 → RUN.
  - RUN, busy=1:
    - If the FIFO is empty on entry or after a pop → DONE.
    - Otherwise a_out/c_out present the head entry; the remaining counter loads cmd_rep on the first cycle of each command.
    - Each cycle, if the counter is 0, pop and advance; otherwise decrement.
    - A command with cmd_rep=R occupies exactly R+1 consecutive cycles.
    - Commands execute back to back with no gap cycle.
  - DONE: a_out=c_out=0, done=1 for one cycle, busy=0 → IDLE. hits holds its value until the next CLEAR.
- Hit counting:
  - In RUN only, hits increments when n_in=1.
  - Saturates at 2^CNT_W−1; no wrap.
- Commands pushed during RUN join the running sequence if they arrive before the FIFO empties.
- Abort:
  - Any state, the cycle after abort=1: state IDLE, FIFO flushed, a_out=c_out=0, fsm_rst=0, busy=0, done=0.
  - A push in the same cycle as abort is discarded.
  - hits is held.
- rst asserted mid-run: immediate return to the reset values above, independent of clk.
- Empty FIFO at start: IDLE → CLEAR → RUN → DONE, giving done three cycles after start, with hits=0.

Optional Feature:
- Macro: C4_SEQ_FIRST_HIT_EN.
- Defined:
  - Adds output first_hit [CNT_W-1:0], plus an internal RUN cycle index that starts at 0 on the first RUN cycle and saturates.
  - first_hit captures the index of the first RUN cycle with n_in=1.
  - first_hit is all-ones after reset or CLEAR, and when no hit occurs.
  - It is held after capture until the next CLEAR.
- Not defined: no port, no index counter; all other behaviour identical.

Test Plan:
- Reset mid-RUN with 3 queued commands → all outputs return to reset values asynchronously; cmd_ready=1; FIFO empty after release.
- Push {a=1,c=0,rep=2}, {a=0,c=1,rep=0}, then start → fsm_rst high on the cycle after start; a_out=1 for 3 cycles, then c_out=1 for 1 cycle; done 1 cycle later; busy spans CLEAR through the last command.
- Push 4 commands with no start → cmd_ready=0; a 5th cmd_valid is not accepted; after start and the first pop, cmd_ready=1.
- n_in held 1 with a single command rep=255 and CNT_W=8 → hits saturates at 255.
- abort asserted in the second RUN cycle with 2 queued commands → IDLE next cycle, a_out=c_out=0, FIFO empty, no done; hits keeps its count.
- With C4_SEQ_FIRST_HIT_EN defined, n_in first rises in RUN cycle 5 → first_hit=5; with no rise → first_hit=8'hFF.
